// File: rtl/keypad_cursor_encoder_if.sv
// rtl/keypad_cursor_encoder_if.sv - raw buttons in, cursor position and commit strobe out
interface keypad_cursor_encoder_if #(
  parameter int ROWS = 4,
  parameter int COLS = 6
);
  logic                    btn_up;
  logic                    btn_down;
  logic                    btn_left;
  logic                    btn_right;
  logic                    btn_center;
  logic [4:0]              val;
  logic                    enter_button;
  logic [$clog2(ROWS)-1:0] cursor_row;
  logic [$clog2(COLS)-1:0] cursor_col;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center,
    input  val, enter_button, cursor_row, cursor_col
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center,
    output val, enter_button, cursor_row, cursor_col
  );
endinterface

// File: rtl/keypad_cursor_encoder.sv
// rtl/keypad_cursor_encoder.sv - synchronise, debounce and auto-repeat five buttons into grid cursor moves
module keypad_cursor_encoder #(
  parameter int ROWS            = 4,
  parameter int COLS            = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  keypad_cursor_encoder_if.slave  kp
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int NB   = 5;
  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam int         IDX_CTR   = 4;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [NB-1:0]  raw;
  logic [NB-1:0]  sync1_q, sync2_q, db_q, db_d_q, rise_q;
  logic [DBW-1:0] dbc_q [NB];

  state_t         state_q, state_d;
  logic [1:0]     dir_q, dir_d;
  logic [RCW-1:0] cnt_q, cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [4:0]     val_q, val_d;
  logic           enter_q, enter_d;

  logic           new_rise, do_move;
  logic [1:0]     new_dir, move_dir;

  assign raw = {kp.btn_center, kp.btn_right, kp.btn_left, kp.btn_down, kp.btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      db_d_q  <= '0;
      rise_q  <= '0;
      for (int i = 0; i < NB; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_d_q  <= db_q;
      rise_q  <= db_q & ~db_d_q;
      // Any sample agreeing with the accepted level restarts the stability count.
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]  <= sync2_q[i];
          dbc_q[i] <= '0;
        end else begin
          dbc_q[i] <= dbc_q[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    new_rise = |rise_q[3:0];
    new_dir  = DIR_RIGHT;
    if (rise_q[0])      new_dir = DIR_UP;
    else if (rise_q[1]) new_dir = DIR_DOWN;
    else if (rise_q[2]) new_dir = DIR_LEFT;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    enter_d  = rise_q[IDX_CTR];
    do_move  = 1'b0;
    move_dir = dir_q;

    // A centre rise swallows any direction rise and any repeat move due this cycle.
    case (state_q)
      IDLE: begin
        if (!rise_q[IDX_CTR] && new_rise) begin
          do_move  = 1'b1;
          move_dir = new_dir;
          dir_d    = new_dir;
          cnt_d    = RCW'(REPEAT_DELAY - 1);
          state_d  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!rise_q[IDX_CTR] && new_rise) begin
          do_move  = 1'b1;
          move_dir = new_dir;
          dir_d    = new_dir;
          cnt_d    = RCW'(REPEAT_DELAY - 1);
          state_d  = DELAY;
        end else if (!db_q[dir_q]) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          do_move = !rise_q[IDX_CTR];
          cnt_d   = RCW'(REPEAT_PERIOD - 1);
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - RCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    row_d = row_q;
    col_d = col_q;
    if (do_move) begin
      case (move_dir)
        DIR_UP:   row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
        DIR_DOWN: row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        DIR_LEFT: col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
        default:  col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      endcase
    end
    val_d = 5'(int'(row_d) * COLS + int'(col_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
      enter_q <= enter_d;
    end
  end

  assign kp.val          = val_q;
  assign kp.enter_button = enter_q;
  assign kp.cursor_row   = row_q;
  assign kp.cursor_col   = col_q;

endmodule

// File: tb/tb_keypad_cursor_encoder.sv
// tb/tb_keypad_cursor_encoder.sv - scoreboard bench for keypad_cursor_encoder with a cursor model
module tb_keypad_cursor_encoder;
  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int DB   = 4;
  localparam int RD   = 8;
  localparam int RP   = 4;

  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000, B_CTR = 5'b10000;

  typedef struct {
    int cyc;
    bit en;
    int val;
    int row;
    int col;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_row = 0;
  int   m_col = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_cursor_encoder_if #(.ROWS(ROWS), .COLS(COLS)) kp();

  keypad_cursor_encoder #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp(kp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    kp.btn_up     = m[0];
    kp.btn_down   = m[1];
    kp.btn_left   = m[2];
    kp.btn_right  = m[3];
    kp.btn_center = m[4];
  endtask

  task automatic push(input int at, input bit en);
    sb.push_back('{cyc: at, en: en, val: m_row * COLS + m_col, row: m_row, col: m_col});
  endtask

  task automatic model_move(input int d);
    case (d)
      0:       m_row = (m_row == 0) ? ROWS - 1 : m_row - 1;
      1:       m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      2:       m_col = (m_col == 0) ? COLS - 1 : m_col - 1;
      default: m_col = (m_col == COLS - 1) ? 0 : m_col + 1;
    endcase
  endtask

  // Drive mask for h cycles; first action lands DB+4 cycles later, repeats until the debounced fall.
  task automatic press(input logic [4:0] m, input int h);
    int c, d, t;
    step();
    c = cyc;
    set_btn(m);
    if (m[4]) begin
      push(c + DB + 4, 1'b1);
    end else if (m[3:0] != 0) begin
      d = m[0] ? 0 : m[1] ? 1 : m[2] ? 2 : 3;
      t = c + DB + 4;
      while (t <= c + h + DB + 2) begin
        model_move(d);
        push(t, 1'b0);
        t += (t == c + DB + 4) ? RD : RP;
      end
    end
    step(h);
    set_btn(5'b0);
    step(12);
  endtask

  initial begin
    logic [31:0] prev_val, prev_row, prev_col;
    ev_t e;
    prev_val = 0;
    prev_row = 0;
    prev_col = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (kp.enter_button !== 1'b0 || kp.val !== prev_val[4:0] ||
            kp.cursor_row !== prev_row[1:0] || kp.cursor_col !== prev_col[2:0]) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_event observed=cyc%0d val%0d enter%0d expected=none",
                   cyc, kp.val, kp.enter_button);
          end else begin
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_enter", 32'(kp.enter_button), e.en);
            chk("ev_val", 32'(kp.val), e.val);
            chk("ev_row", 32'(kp.cursor_row), e.row);
            chk("ev_col", 32'(kp.cursor_col), e.col);
          end
        end
      end
      prev_val = 32'(kp.val);
      prev_row = 32'(kp.cursor_row);
      prev_col = 32'(kp.cursor_col);
    end
  end

  initial begin
    int c;
    set_btn(5'b0);
    rst = 1'b1;
    step(3);
    chk("reset_val", 32'(kp.val), 0);
    chk("reset_row", 32'(kp.cursor_row), 0);
    chk("reset_col", 32'(kp.cursor_col), 0);
    chk("reset_enter", 32'(kp.enter_button), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step(2);

    press(B_RIGHT, 8);
    chk("right_val", 32'(kp.val), 1);

    repeat (4) begin
      set_btn(B_CTR);
      step(2);
      set_btn(5'b0);
      step(3);
    end
    step(10);
    press(B_CTR, 10);

    press(B_UP, 8);
    press(B_DOWN, 8);
    chk("down_wrap_val", 32'(kp.val), 1);
    repeat (3) press(B_LEFT, 8);
    chk("left_wrap_val", 32'(kp.val), 4);
    press(B_UP, 8);
    repeat (3) press(B_LEFT, 8);
    chk("exe_val", 32'(kp.val), 19);
    press(B_CTR, 8);

    press(B_LEFT, 8);
    press(B_DOWN, 8);
    chk("home_val", 32'(kp.val), 0);
    press(B_UP, 35);

    press(B_DOWN, 8);
    repeat (2) press(B_RIGHT, 8);
    chk("pos12_val", 32'(kp.val), 8);
    press(B_CTR | B_RIGHT, 8);
    press(B_UP | B_LEFT, 8);
    chk("up_left_val", 32'(kp.val), 2);

    step();
    c = cyc;
    set_btn(B_DOWN);
    model_move(1); push(c + DB + 4, 1'b0);
    model_move(1); push(c + DB + 4 + RD, 1'b0);
    model_move(1); push(c + DB + 4 + RD + RP, 1'b0);
    step(22);
    rst = 1'b1;
    step(2);
    chk("midrst_val", 32'(kp.val), 0);
    chk("midrst_row", 32'(kp.cursor_row), 0);
    chk("midrst_col", 32'(kp.cursor_col), 0);
    chk("midrst_enter", 32'(kp.enter_button), 0);
    m_row = 0;
    m_col = 0;
    c = cyc;
    rst = 1'b0;
    model_move(1);
    push(c + DB + 4, 1'b0);
    step(8);
    set_btn(5'b0);
    step(20);
    chk("after_rst_val", 32'(kp.val), 6);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
